// File: rtl/squarer_rr_sched.sv
// Round-robin scheduler that time-shares one combinational 5-bit squarer among NREQ
// requesters and returns each registered square tagged with the owning requester index.
module squarer_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_a,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        sq_a,
  input  logic [9:0]        sq_p,
  output logic              res_valid,
  output logic [9:0]        res_p,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [4:0]     op_q, op_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [9:0]     res_p_q, res_p_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_valid_q, res_valid_d;

  logic found;
  int   grant_idx;
  int   cand;
  logic accept;

  // Search starts just after the last grant so every valid requester is reached
  // within NREQ grants.
  always_comb begin
    found     = 1'b0;
    grant_idx = 0;
    cand      = 0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = int'(last_q) + k;
      if (cand >= int'(NREQ)) cand = cand - int'(NREQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept = (state_q == StIdle) && found && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    id_d        = id_q;
    last_d      = last_q;
    res_p_d     = res_p_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = req_a[5*grant_idx +: 5];
          id_d    = grant_idx[IDW-1:0];
          last_d  = grant_idx[IDW-1:0];
          state_d = StCalc;
        end
      end
      StCalc: begin
        res_p_d     = sq_p;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      id_q        <= '0;
      last_q      <= IDW'(NREQ - 1);
      res_p_q     <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      id_q        <= id_d;
      last_q      <= last_d;
      res_p_q     <= res_p_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign sq_a      = op_q;
  assign res_valid = res_valid_q;
  assign res_p     = res_p_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_squarer_rr_sched.sv
// Directed self-checking bench for squarer_rr_sched; the shared squarer is modelled here.
module tb_squarer_rr_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_a;
  logic [NREQ-1:0]   req_ready;
  logic [4:0]        sq_a;
  logic [9:0]        sq_p;
  logic              res_valid;
  logic [9:0]        res_p;
  logic [IDW-1:0]    res_id;
  logic              res_ready;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  squarer_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_ready (req_ready),
    .sq_a      (sq_a),
    .sq_p      (sq_p),
    .res_valid (res_valid),
    .res_p     (res_p),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  assign sq_p = 10'(sq_a) * 10'(sq_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_a     = '0;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [4:0] a);
    req_a[5*i +: 5] = a;
  endtask

  // Waits (bounded) for res_valid, then checks id and square; does not consume.
  task automatic expect_result(input string tag, input int exp_id, input int exp_p);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_id"}, 32'(res_id), 32'(exp_id));
      check({tag, "_p"}, 32'(res_p), 32'(exp_p));
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    check("consume_valid_low", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int order2 [5] = '{0, 1, 2, 3, 0};
    int sq2    [5] = '{9, 49, 144, 400, 9};

    // Reset state, with a pending request that must not see req_ready.
    req_valid = 4'b1111;
    req_a     = '0;
    res_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sq_a", 32'(sq_a), 32'd0);
    check("rst_p", 32'(res_p), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);

    // 1: single request, two-edge latency.
    do_reset();
    res_ready = 1'b0;
    set_op(0, 5'd31);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check("t1_calc_busy", 32'(busy), 32'd1);
    check("t1_calc_ready", 32'(req_ready), 32'd0);
    check("t1_calc_sq_a", 32'(sq_a), 32'd31);
    check("t1_calc_valid", 32'(res_valid), 32'd0);
    tick();
    check("t1_done_valid", 32'(res_valid), 32'd1);
    check("t1_done_p", 32'(res_p), 32'd961);
    check("t1_done_id", 32'(res_id), 32'd0);
    consume();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 2: all four valid -> strict rotation with wrap.
    do_reset();
    set_op(0, 5'd3);
    set_op(1, 5'd7);
    set_op(2, 5'd12);
    set_op(3, 5'd20);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      expect_result($sformatf("t2_%0d", i), order2[i], sq2[i]);
      consume();
    end
    req_valid = '0;

    // 3: backpressure holds the result and blocks new accepts.
    do_reset();
    res_ready = 1'b0;
    set_op(0, 5'd5);
    set_op(2, 5'd9);
    req_valid = 4'b0101;
    expect_result("t3_first", 0, 25);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t3_hold_%0d", i), {res_valid, 19'd0, res_id, res_p},
            {1'b1, 19'd0, 2'd0, 10'd25});
      check($sformatf("t3_noready_%0d", i), 32'(req_ready), 32'd0);
    end
    req_valid = 4'b0100;
    consume();
    check("t3_resume_ready", 32'(req_ready), 32'b0100);
    expect_result("t3_second", 2, 81);
    consume();
    req_valid = '0;

    // 4: fairness between requesters 1 and 3.
    do_reset();
    set_op(1, 5'd2);
    set_op(3, 5'd3);
    req_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      expect_result($sformatf("t4_%0d", i), (i % 2 == 0) ? 1 : 3, (i % 2 == 0) ? 4 : 9);
      consume();
    end
    req_valid = '0;

    // 5a: reset during CALC.
    do_reset();
    set_op(2, 5'd6);
    set_op(3, 5'd7);
    req_valid = 4'b0100;
    tick();
    check("t5a_in_calc", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5a_valid", 32'(res_valid), 32'd0);
    check("t5a_busy", 32'(busy), 32'd0);
    check("t5a_sq_a", 32'(sq_a), 32'd0);
    req_valid = 4'b1100;
    tick();
    rst_n = 1'b1;
    expect_result("t5a_next", 2, 36);
    req_valid = '0;
    consume();

    // 5b: reset during DONE; next grant searches from requester 0.
    do_reset();
    res_ready = 1'b0;
    set_op(0, 5'd4);
    set_op(3, 5'd7);
    req_valid = 4'b1000;
    expect_result("t5b_first", 3, 49);
    rst_n = 1'b0;
    #1;
    check("t5b_valid", 32'(res_valid), 32'd0);
    check("t5b_busy", 32'(busy), 32'd0);
    check("t5b_sq_a", 32'(sq_a), 32'd0);
    req_valid = 4'b1001;
    tick();
    rst_n = 1'b1;
    #1;
    check("t5b_ready", 32'(req_ready), 32'b0001);
    expect_result("t5b_next", 0, 16);
    req_valid = '0;
    consume();

    // 6: exhaustive operands through requester 2.
    do_reset();
    req_valid = 4'b0100;
    for (int a = 0; a < 32; a++) begin
      set_op(2, 5'(a));
      expect_result($sformatf("t6_a%0d", a), 2, a * a);
      check($sformatf("t6_bit1_a%0d", a), 32'(res_p[1]), 32'd0);
      consume();
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
